// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encoding and datapath control codes for the multicycle controller
package mc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [3:0] {I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_ILL} itype_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies the current instruction word into a supported type or illegal
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output itype_t      itype,
  output logic        illegal
);
  logic [5:0] fn;
  assign fn = instr[5:0];
  // all-zero word is nop; it must win over the R-type funct lookup
  always_comb begin
    itype = I_ILL;
    if (instr == 32'd0) itype = I_NOP;
    else case (instr[31:26])
      OP_RTYPE: itype = fn == FN_ADDU ? I_ADDU : fn == FN_SUBU ? I_SUBU : fn == FN_JR ? I_JR : I_ILL;
      OP_ORI:   itype = I_ORI;
      OP_LUI:   itype = I_LUI;
      OP_LW:    itype = I_LW;
      OP_SW:    itype = I_SW;
      OP_BEQ:   itype = I_BEQ;
      OP_JAL:   itype = I_JAL;
      default:  itype = I_ILL;
    endcase
  end
  assign illegal = itype == I_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM with retired-instruction counter
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        IRWrite,
  output logic        imem_req,
  output logic [3:0]  ALUCtrl,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ExtOp,
  output logic        ALUSrc,
  output logic        nPC_Sel,
  output logic        Jump,
  output logic        PCSel,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic [31:0] retired
);
  state_t     state, state_nx;
  itype_t     itype;
  logic       is_ill;
  logic [3:0] alu_c;
  logic       alu_s;
  logic [1:0] ext_c, dst_c;
  mc_decode u_dec (.instr(Instr), .itype(itype), .illegal(is_ill));
  // per-type ALU/extend/destination controls, reused unchanged by EXEC, MEM and WB
  always_comb begin
    alu_c = ALU_ADD;
    alu_s = 1'b0;
    ext_c = EXT_ZERO;
    dst_c = DST_RT;
    case (itype)
      I_ADDU:     dst_c = DST_RD;
      I_SUBU:     begin alu_c = ALU_SUB; dst_c = DST_RD; end
      I_ORI:      begin alu_c = ALU_OR; alu_s = 1'b1; end
      I_LUI:      begin alu_c = ALU_OR; alu_s = 1'b1; ext_c = EXT_LUI; end
      I_LW, I_SW: begin alu_s = 1'b1; ext_c = EXT_SIGN; end
      I_BEQ:      begin alu_c = ALU_SUB; ext_c = EXT_SIGN; end
      default:    ;
    endcase
  end
  // next state and strobes; everything stays 0 while reset is held low
  always_comb begin
    state_nx = state;
    IRWrite  = 1'b0;
    imem_req = 1'b0;
    ALUCtrl  = ALU_ADD;
    RegDst   = DST_RT;
    MemtoReg = M2R_ALU;
    ExtOp    = EXT_ZERO;
    ALUSrc   = 1'b0;
    nPC_Sel  = 1'b0;
    Jump     = 1'b0;
    PCSel    = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    if (reset) case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
        state_nx = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal  = is_ill;
        PCWrite  = is_ill;
        state_nx = is_ill ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        ALUCtrl  = alu_c;
        ALUSrc   = alu_s;
        ExtOp    = ext_c;
        RegDst   = dst_c;
        state_nx = S_WB;
        case (itype)
          I_LW, I_SW: state_nx = S_MEM;
          I_BEQ: begin nPC_Sel = 1'b1; PCWrite = 1'b1; state_nx = S_FETCH; end
          I_JAL: begin
            Jump     = 1'b1;
            PCWrite  = 1'b1;
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = M2R_PC4;
            state_nx = S_FETCH;
          end
          I_JR: begin Jump = 1'b1; PCSel = 1'b1; PCWrite = 1'b1; state_nx = S_FETCH; end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUCtrl  = alu_c;
        ALUSrc   = alu_s;
        ExtOp    = ext_c;
        RegDst   = dst_c;
        MemRead  = itype == I_LW;
        MemWrite = itype == I_SW;
        PCWrite  = dmem_ready && itype != I_LW;
        state_nx = !dmem_ready ? S_MEM : itype == I_LW ? S_WB : S_FETCH;
      end
      S_WB: begin
        ALUCtrl  = alu_c;
        ALUSrc   = alu_s;
        ExtOp    = ext_c;
        RegDst   = dst_c;
        RegWrite = itype != I_NOP;
        MemtoReg = itype == I_LW ? M2R_MEM : M2R_ALU;
        PCWrite  = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end
  // state register; reset abandons any pending fetch or memory wait
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_nx;
  // one retirement per PCWrite, illegal skips included; wraps naturally
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired <= 32'd0;
    else if (PCWrite) retired <= retired + 32'd1;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for the multicycle controller
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        imem_ready, dmem_ready;
  logic        IRWrite, imem_req, ALUSrc, nPC_Sel, Jump, PCSel, PCWrite;
  logic        RegWrite, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [1:0]  RegDst, MemtoReg, ExtOp;
  logic [31:0] retired;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_ret = 32'd0;
  int          irw_cyc, mr_cnt;
  logic [3:0]  s_alu;
  logic [1:0]  s_dst, s_m2r, s_ext;
  logic        s_src, s_npc, s_jmp, s_sel, s_rw, s_mw, s_ill;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IRWrite(IRWrite), .imem_req(imem_req), .ALUCtrl(ALUCtrl), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ExtOp(ExtOp), .ALUSrc(ALUSrc), .nPC_Sel(nPC_Sel), .Jump(Jump), .PCSel(PCSel), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // runs one instruction from FETCH, snapshots the PCWrite cycle, checks latency and count
  task automatic run(input string tag, input logic [31:0] ins, input int iw, input int dw, input int lat);
    int cyc = 0;
    int ic = 0;
    int dc = 0;
    bit done = 0;
    irw_cyc = 0;
    mr_cnt = 0;
    Instr = ins;
    while (!done && cyc < 40) begin
      cyc++;
      imem_ready = ic >= iw;
      dmem_ready = dc >= dw;
      #1;
      if (IRWrite && irw_cyc == 0) irw_cyc = cyc;
      if (imem_req) ic++;
      if (MemRead || MemWrite) dc++;
      if (MemRead) mr_cnt++;
      if (PCWrite) begin
        done = 1;
        {s_alu, s_dst, s_m2r, s_ext} = {ALUCtrl, RegDst, MemtoReg, ExtOp};
        {s_src, s_npc, s_jmp, s_sel, s_rw, s_mw, s_ill} = {ALUSrc, nPC_Sel, Jump, PCSel, RegWrite, MemWrite, illegal};
      end
      @(negedge clk);
    end
    exp_ret++;
    check({tag, " latency"}, cyc, lat);
    #1;
    check({tag, " retired"}, retired, exp_ret);
    check({tag, " back in fetch"}, {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    Instr = 32'h0022_1821;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("reset imem_req", {31'd0, imem_req}, 32'd0);
    check("reset IRWrite", {31'd0, IRWrite}, 32'd0);
    check("reset retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run("addu", 32'h0022_1821, 0, 0, 4);
    check("addu IRWrite cycle", irw_cyc, 1);
    check("addu RegWrite", {31'd0, s_rw}, 32'd1);
    check("addu RegDst", {30'd0, s_dst}, 32'd1);
    check("addu ALUCtrl", {28'd0, s_alu}, 32'd0);
    run("lw", 32'h8C22_0004, 0, 3, 8);
    check("lw MemRead cycles", mr_cnt, 4);
    check("lw MemtoReg", {30'd0, s_m2r}, 32'd1);
    check("lw RegDst", {30'd0, s_dst}, 32'd0);
    check("lw ExtOp", {30'd0, s_ext}, 32'd1);
    run("jal", 32'h0C00_0010, 0, 0, 3);
    check("jal Jump/PCSel/RegWrite", {29'd0, s_jmp, s_sel, s_rw}, 32'b101);
    check("jal RegDst", {30'd0, s_dst}, 32'd2);
    check("jal MemtoReg", {30'd0, s_m2r}, 32'd2);
    run("illegal op", 32'hFC00_0000, 0, 0, 2);
    check("illegal op pulse", {31'd0, s_ill}, 32'd1);
    run("subu", 32'h0022_1823, 0, 0, 4);
    check("subu ALUCtrl", {28'd0, s_alu}, 32'd1);
    check("subu RegDst", {30'd0, s_dst}, 32'd1);
    run("ori", 32'h3422_0005, 0, 0, 4);
    check("ori ALUCtrl", {28'd0, s_alu}, 32'd2);
    check("ori ALUSrc/ExtOp", {29'd0, s_src, s_ext}, 32'b100);
    run("lui", 32'h3C01_1234, 0, 0, 4);
    check("lui ExtOp", {30'd0, s_ext}, 32'd2);
    check("lui RegWrite/ALUSrc", {30'd0, s_rw, s_src}, 32'b11);
    run("beq", 32'h1022_0003, 0, 0, 3);
    check("beq nPC_Sel/Jump", {30'd0, s_npc, s_jmp}, 32'b10);
    check("beq ALUCtrl/ExtOp", {26'd0, s_alu, s_ext}, 32'b0001_01);
    run("jr", 32'h03E0_0008, 0, 0, 3);
    check("jr Jump/PCSel/RegWrite", {29'd0, s_jmp, s_sel, s_rw}, 32'b110);
    run("sw", 32'hAC22_0004, 0, 0, 4);
    check("sw MemWrite/ALUSrc", {30'd0, s_mw, s_src}, 32'b11);
    check("sw RegWrite", {31'd0, s_rw}, 32'd0);
    run("nop", 32'h0000_0000, 0, 0, 4);
    check("nop RegWrite", {31'd0, s_rw}, 32'd0);
    run("addu fetch wait", 32'h0022_1821, 2, 0, 6);
    run("illegal funct", 32'h0000_0040, 0, 0, 2);
    check("illegal funct pulse", {31'd0, s_ill}, 32'd1);
    Instr = 32'hAC22_0004;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("sw wait MemWrite", {31'd0, MemWrite}, 32'd1);
    @(negedge clk);
    #1;
    check("sw wait held", {30'd0, MemWrite, PCWrite}, 32'b10);
    reset = 1'b0;
    #1;
    check("mid-wait reset MemWrite", {31'd0, MemWrite}, 32'd0);
    check("mid-wait reset imem_req", {31'd0, imem_req}, 32'd0);
    check("mid-wait reset retired", retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dmem_ready = 1'b1;
    exp_ret = 32'd0;
    #1;
    check("post-reset fetch", {30'd0, imem_req, MemWrite}, 32'b10);
    run("addu after reset", 32'h0022_1821, 0, 0, 4);
    dut.retired = 32'hFFFF_FFFF;
    exp_ret = 32'hFFFF_FFFF;
    run("wrap nop", 32'h0000_0000, 0, 0, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
